cordic_sqrt_sequencer: RTL

CORDIC_SQRT_SEQUENCER -- requirements
Module: cordic_sqrt_sequencer

---
 rtl/cordic_sqrt_sequencer.sv | 100 ++++++++++
 1 files changed

// File: rtl/cordic_sqrt_sequencer.sv
// Iteration sequencer for a hyperbolic CORDIC square-root core: issues one
// {X,Y,shift} step per round trip and returns the final X.
module cordic_sqrt_sequencer #(
  parameter int WIDTH               = 16,
  parameter int MAX_ITERATION_WIDTH = 10,
  parameter int NUM_ITER            = 8
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   enable,
  input  logic [2*WIDTH-1:0]                     s_axi_data,
  input  logic                                   s_axi_valid,
  output logic                                   s_axi_ready,
  output logic [2*WIDTH+MAX_ITERATION_WIDTH-1:0] c_data,
  output logic                                   c_valid,
  input  logic [2*WIDTH-1:0]                     c_res_data,
  input  logic                                   c_res_valid,
  output logic                                   c_res_ready,
  output logic [WIDTH-1:0]                       m_axi_data,
  output logic                                   m_axi_valid,
  input  logic                                   m_axi_ready
);

  localparam int SW = MAX_ITERATION_WIDTH;
  // Shifts 4 and 13 are issued twice for hyperbolic convergence.
  localparam int TOTAL_STEPS = NUM_ITER + ((NUM_ITER >= 4) ? 1 : 0) + ((NUM_ITER >= 13) ? 1 : 0);
  localparam logic [SW:0] LAST_STEP = (SW+1)'(TOTAL_STEPS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  x;
  logic [WIDTH-1:0]  y;
  logic [SW-1:0]     shift;
  logic              rep;
  logic [SW:0]       step;
  logic [WIDTH-1:0]  result;
  logic              rep_shift;

  assign rep_shift = (shift == SW'(4)) || (shift == SW'(13));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state  <= IDLE;
      x      <= '0;
      y      <= '0;
      shift  <= '0;
      rep    <= 1'b0;
      step   <= '0;
      result <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (s_axi_valid) begin
            x     <= s_axi_data[2*WIDTH-1:WIDTH];
            y     <= s_axi_data[WIDTH-1:0];
            shift <= SW'(1);
            rep   <= 1'b0;
            step  <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          // Going back through ISSUE keeps a still-high core valid from
          // being counted as the next step's result.
          if (c_res_valid) begin
            x <= c_res_data[2*WIDTH-1:WIDTH];
            y <= c_res_data[WIDTH-1:0];
            if (step == LAST_STEP) begin
              result <= c_res_data[2*WIDTH-1:WIDTH];
              state  <= DONE;
            end else begin
              step  <= step + (SW+1)'(1);
              state <= ISSUE;
              if (rep_shift && !rep) begin
                rep <= 1'b1;
              end else begin
                rep   <= 1'b0;
                shift <= shift + SW'(1);
              end
            end
          end
        end
        DONE: begin
          if (m_axi_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_axi_ready = (state == IDLE);
  assign c_valid     = (state == ISSUE);
  assign c_res_ready = (state == WAIT);
  assign m_axi_valid = (state == DONE);
  assign c_data      = {x, y, shift};
  assign m_axi_data  = result;

endmodule
